// File: rtl/i2c_mem_arbiter_if.sv
// Requester and Wishbone signal bundle for the two-port RAM arbiter; master is the arbiter view.
interface i2c_mem_arbiter_if #(
  parameter int ADR_W = 8
);
  logic             r0_req;
  logic             r0_we;
  logic [ADR_W-1:0] r0_adr;
  logic [7:0]       r0_wdat;
  logic             r0_ack;
  logic             r0_err;
  logic [7:0]       r0_rdat;

  logic             r1_req;
  logic             r1_we;
  logic [ADR_W-1:0] r1_adr;
  logic [7:0]       r1_wdat;
  logic             r1_ack;
  logic             r1_err;
  logic [7:0]       r1_rdat;

  logic [ADR_W-1:0] wb_adr_o;
  logic [7:0]       wb_dat_o;
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic [3:0]       wb_sel_o;
  logic [2:0]       wb_cti_o;
  logic [1:0]       wb_bte_o;
  logic [7:0]       wb_dat_i;
  logic             wb_ack_i;
  logic             wb_err_i;

  logic             gnt_o;
  logic             busy_o;

  modport master (
    input  r0_req, r0_we, r0_adr, r0_wdat,
    output r0_ack, r0_err, r0_rdat,
    input  r1_req, r1_we, r1_adr, r1_wdat,
    output r1_ack, r1_err, r1_rdat,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output gnt_o, busy_o
  );

  modport slave (
    output r0_req, r0_we, r0_adr, r0_wdat,
    input  r0_ack, r0_err, r0_rdat,
    output r1_req, r1_we, r1_adr, r1_wdat,
    input  r1_ack, r1_err, r1_rdat,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  gnt_o, busy_o
  );
endinterface

// File: rtl/i2c_mem_arbiter.sv
// Round-robin arbiter of two byte requesters onto one Wishbone single-cycle master; cycle starts 1 clk after request,
// requesters are held until the slave acks/errs (plus one turnaround clock). WB_ARB_TIMEOUT_EN adds a bus watchdog.
module i2c_mem_arbiter #(
  parameter int ADR_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  i2c_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t state, state_nxt;
  logic   last;
  logic   win;
  logic   grant;
  logic   fin_ok;
  logic   fin_err;
  logic   timeout;

  // On a tie the port that was not granted last wins; a lone request always wins.
  assign win = bus.r0_req ? (bus.r1_req & ~last) : 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  assign timeout = (state == BUS) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || state != BUS) to_cnt <= '0;
    else                       to_cnt <= to_cnt + 1'b1;
  end
`else
  logic timeout_unused;
  assign timeout        = 1'b0;
  assign timeout_unused = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          grant     = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (bus.wb_err_i || timeout) begin
          fin_err   = 1'b1;
          state_nxt = DONE;
        end else if (bus.wb_ack_i) begin
          fin_ok    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.wb_cyc_o <= 1'b0;
      bus.wb_stb_o <= 1'b0;
      bus.wb_we_o  <= 1'b0;
      bus.wb_adr_o <= '0;
      bus.wb_dat_o <= '0;
      bus.gnt_o    <= 1'b0;
      last         <= 1'b1;
      bus.r0_ack   <= 1'b0;
      bus.r0_err   <= 1'b0;
      bus.r1_ack   <= 1'b0;
      bus.r1_err   <= 1'b0;
      bus.r0_rdat  <= '0;
      bus.r1_rdat  <= '0;
    end else begin
      bus.r0_ack <= fin_ok  & ~bus.gnt_o;
      bus.r1_ack <= fin_ok  &  bus.gnt_o;
      bus.r0_err <= fin_err & ~bus.gnt_o;
      bus.r1_err <= fin_err &  bus.gnt_o;

      if (grant) begin
        bus.gnt_o    <= win;
        bus.wb_adr_o <= win ? bus.r1_adr  : bus.r0_adr;
        bus.wb_dat_o <= win ? bus.r1_wdat : bus.r0_wdat;
        bus.wb_we_o  <= win ? bus.r1_we   : bus.r0_we;
        bus.wb_cyc_o <= 1'b1;
        bus.wb_stb_o <= 1'b1;
      end

      if (fin_ok || fin_err) begin
        bus.wb_cyc_o <= 1'b0;
        bus.wb_stb_o <= 1'b0;
        bus.wb_we_o  <= 1'b0;
        last         <= bus.gnt_o;
      end

      // Read data is only captured on a clean ack; an error leaves the old value visible.
      if (fin_ok && !bus.wb_we_o) begin
        if (bus.gnt_o) bus.r1_rdat <= bus.wb_dat_i;
        else           bus.r0_rdat <= bus.wb_dat_i;
      end
    end
  end

  assign bus.busy_o   = (state != IDLE);
  assign bus.wb_sel_o = 4'hF;
  assign bus.wb_cti_o = 3'b111;
  assign bus.wb_bte_o = 2'b00;

endmodule
